// File: rtl/mccpu_mem_pkg.sv
// Shared types and constants for the multicycle-CPU memory bridge.
// Holds the FSM state encoding, the timeout read-data default and the legal TIMEOUT range.
package mccpu_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
   localparam int unsigned TIMEOUT_MIN      = 32'd2;
   localparam int unsigned TIMEOUT_MAX      = 32'd255;

endpackage

// File: rtl/mccpu_mem_bridge_if.sv
// Memory-side request/acknowledge bus of the bridge.
// The bridge drives it through the master modport; the memory uses the slave modport.
interface mccpu_mem_bridge_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mccpu_mem_timer.sv
// Wait-cycle counter: clears on request, counts while enabled, saturates at TIMEOUT-1.
// expire flags the last permitted wait cycle so the bridge can abort the access.
module mccpu_mem_timer #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic clrn,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_r;

   // Counter register: clear has priority, then saturating increment.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (en && (cnt_r != LAST)) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expire = (cnt_r == LAST);

endmodule

// File: rtl/mccpu_mem_bridge.sv
// Converts single-cycle CPU memory accesses into req/ack memory transactions,
// stalling the CPU until the data is ready and aborting accesses that never complete.
module mccpu_mem_bridge
   import mccpu_mem_pkg::*;
#(
   parameter int unsigned   AW       = 32,
   parameter int unsigned   DW       = 32,
   parameter int unsigned   TIMEOUT  = 16,
   parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
   input  logic                 clk,
   input  logic                 clrn,
   input  logic                 cpu_rd,
   input  logic                 cpu_wr,
   input  logic [AW-1:0]        cpu_addr,
   input  logic [DW-1:0]        cpu_wdata,
   output logic [DW-1:0]        cpu_rdata,
   output logic                 stall,
   output logic                 done_o,
   output logic                 err,
   mccpu_mem_bridge_if.master   mem
);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   state_t        state_r;
   state_t        state_nxt_s;
   logic          stall_s;
   logic          req_s;
   logic          expire_s;
   logic          tmr_clr_s;
   logic          tmr_en_s;
   logic          mem_req_r;
   logic          mem_we_r;
   logic [AW-1:0] mem_addr_r;
   logic [DW-1:0] mem_wdata_r;
   logic [DW-1:0] rdata_r;
   logic          err_r;
   logic          done_r;

   assign req_s     = cpu_rd | cpu_wr;
   assign tmr_en_s  = (state_r == WAIT);
   // Counter restarts outside WAIT and on the ack edge, so every access begins at zero.
   assign tmr_clr_s = (state_r != WAIT) | mem.mem_ack;

   mccpu_mem_timer #(
      .TIMEOUT (TIMEOUT),
      .CW      (CW)
   ) u_timer (
      .clk    (clk),
      .clrn   (clrn),
      .clr    (tmr_clr_s),
      .en     (tmr_en_s),
      .expire (expire_s)
   );

   // Next-state and stall decode; stall rises in the request cycle itself.
   always_comb begin
      state_nxt_s = state_r;
      stall_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_s) begin
               stall_s     = 1'b1;
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT: begin
            stall_s = 1'b1;
            if (mem.mem_ack || expire_s) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         DONE: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Bus, read-data and status registers; ack beats a same-cycle timeout.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
         rdata_r     <= '0;
         err_r       <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= (state_nxt_s == DONE);
         case (state_r)
            IDLE: begin
               if (req_s) begin
                  mem_req_r   <= 1'b1;
                  mem_we_r    <= cpu_wr;
                  mem_addr_r  <= cpu_addr;
                  mem_wdata_r <= cpu_wdata;
               end else begin
                  mem_req_r <= 1'b0;
               end
            end
            WAIT: begin
               if (mem.mem_ack) begin
                  mem_req_r <= 1'b0;
                  mem_we_r  <= 1'b0;
                  rdata_r   <= mem_we_r ? '0 : mem.mem_rdata;
               end else if (expire_s) begin
                  mem_req_r <= 1'b0;
                  mem_we_r  <= 1'b0;
                  err_r     <= 1'b1;
                  rdata_r   <= ERR_DATA;
               end else begin
                  mem_req_r <= 1'b1;
               end
            end
            default: begin
               mem_req_r <= 1'b0;
               mem_we_r  <= 1'b0;
            end
         endcase
      end
   end

   assign stall         = stall_s;
   assign done_o        = done_r;
   assign err           = err_r;
   assign cpu_rdata     = rdata_r;
   assign mem.mem_req   = mem_req_r;
   assign mem.mem_we    = mem_we_r;
   assign mem.mem_addr  = mem_addr_r;
   assign mem.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_mccpu_mem_bridge.sv
// Self-checking bench: one bridge with the default timeout for the access scenarios,
// a second with TIMEOUT=4 for the abort path; read data is tracked through scoreboard queues.
module tb_mccpu_mem_bridge;
   import mccpu_mem_pkg::*;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   always #5 clk = ~clk;

   logic        a_rd, a_wr, a_stall, a_done, a_err;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        b_rd, b_wr, b_stall, b_done, b_err;
   logic [31:0] b_addr, b_wdata, b_rdata;

   mccpu_mem_bridge_if #(.AW(32), .DW(32)) a_mem ();
   mccpu_mem_bridge_if #(.AW(32), .DW(32)) b_mem ();

   mccpu_mem_bridge #(.AW(32), .DW(32), .TIMEOUT(16)) dut_a (
      .clk(clk), .clrn(clrn), .cpu_rd(a_rd), .cpu_wr(a_wr), .cpu_addr(a_addr),
      .cpu_wdata(a_wdata), .cpu_rdata(a_rdata), .stall(a_stall), .done_o(a_done),
      .err(a_err), .mem(a_mem.master)
   );

   mccpu_mem_bridge #(.AW(32), .DW(32), .TIMEOUT(4)) dut_b (
      .clk(clk), .clrn(clrn), .cpu_rd(b_rd), .cpu_wr(b_wr), .cpu_addr(b_addr),
      .cpu_wdata(b_wdata), .cpu_rdata(b_rdata), .stall(b_stall), .done_o(b_done),
      .err(b_err), .mem(b_mem.master)
   );

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];
   logic [31:0] b_q[$];
   logic [31:0] last_rdata = 32'h0;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "bench watchdog expired");
   end

   task automatic test_reset();
      a_rd = 1'b0; a_wr = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
      b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
      a_mem.mem_ack = 1'b0; a_mem.mem_rdata = 32'h0;
      b_mem.mem_ack = 1'b0; b_mem.mem_rdata = 32'h0;
      clrn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      vectors++;
      if ({a_mem.mem_req, a_mem.mem_we, a_stall, a_done, a_err} !== 5'b00000 ||
          a_mem.mem_addr !== 32'h0 || a_mem.mem_wdata !== 32'h0 || a_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_a: got req/we/stall/done/err=%b addr=%h wdata=%h rdata=%h want all zero",
                  {a_mem.mem_req, a_mem.mem_we, a_stall, a_done, a_err}, a_mem.mem_addr, a_mem.mem_wdata, a_rdata);
      end
      vectors++;
      if ({b_mem.mem_req, b_err, b_done} !== 3'b000 || b_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_b: got req/err/done=%b rdata=%h want zero", {b_mem.mem_req, b_err, b_done}, b_rdata);
      end
      @(negedge clk);
      clrn = 1'b1;
   endtask

   // One CPU access on bridge A; inputs stay held through DONE, as the CPU would.
   task automatic access_a(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int ack_wait, input logic [31:0] ack_data);
      logic [31:0] exp_rd;
      int          stalls;
      @(negedge clk);
      a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wdata;
      exp_q.push_back(wr ? 32'h0 : ack_data);
      #1;
      vectors++;
      if (a_stall !== 1'b1 || a_mem.mem_req !== 1'b0 || a_done !== 1'b0) begin
         miscompares++;
         $display("FAIL req_cycle: got stall=%b req=%b done=%b want 1 0 0", a_stall, a_mem.mem_req, a_done);
      end
      stalls = 1;
      for (int w = 1; w <= ack_wait; w++) begin
         @(negedge clk);
         a_mem.mem_ack   = (w == ack_wait);
         a_mem.mem_rdata = (w == ack_wait) ? ack_data : 32'h0;
         #1;
         if (a_stall === 1'b1) stalls++;
         vectors++;
         if (a_mem.mem_req !== 1'b1 || a_mem.mem_we !== wr || a_mem.mem_addr !== addr || a_mem.mem_wdata !== wdata) begin
            miscompares++;
            $display("FAIL wait_bus[%0d]: got req=%b we=%b addr=%h wdata=%h want 1 %b %h %h",
                     w, a_mem.mem_req, a_mem.mem_we, a_mem.mem_addr, a_mem.mem_wdata, wr, addr, wdata);
         end
      end
      @(negedge clk);
      a_mem.mem_ack = 1'b0; a_mem.mem_rdata = 32'h0;
      #1;
      vectors++;
      if (stalls != ack_wait + 1) begin
         miscompares++;
         $display("FAIL stall_count: got %0d want %0d", stalls, ack_wait + 1);
      end
      vectors++;
      if (a_done !== 1'b1 || a_stall !== 1'b0 || a_mem.mem_req !== 1'b0 || a_err !== 1'b0) begin
         miscompares++;
         $display("FAIL done_cycle: got done=%b stall=%b req=%b err=%b want 1 0 0 0", a_done, a_stall, a_mem.mem_req, a_err);
      end
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard: got done with empty queue want pending entry");
      end else begin
         exp_rd = exp_q.pop_front();
         if (a_rdata !== exp_rd) begin
            miscompares++;
            $display("FAIL rdata: got %h want %h", a_rdata, exp_rd);
         end
         last_rdata = exp_rd;
      end
   endtask

   task automatic idle_a(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         a_rd = 1'b0; a_wr = 1'b0;
         #1;
         vectors++;
         if (a_stall !== 1'b0 || a_mem.mem_req !== 1'b0 || a_done !== 1'b0 || a_rdata !== last_rdata) begin
            miscompares++;
            $display("FAIL idle: got stall=%b req=%b done=%b rdata=%h want 0 0 0 %h",
                     a_stall, a_mem.mem_req, a_done, a_rdata, last_rdata);
         end
      end
   endtask

   task automatic test_fetch();
      access_a(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h2008_0005);
      idle_a(2);
   endtask

   task automatic test_store();
      access_a(1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 5, 32'h7777_7777);
      idle_a(1);
   endtask

   task automatic test_collision();
      access_a(1'b1, 1'b1, 32'h0000_00C0, 32'h1357_9BDF, 2, 32'h9999_0000);
      idle_a(1);
   endtask

   task automatic test_back_to_back();
      access_a(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'hA5A5_0001);
      access_a(1'b1, 1'b0, 32'h0000_0104, 32'h0, 3, 32'hA5A5_0002);
      idle_a(1);
   endtask

   task automatic test_spurious();
      @(negedge clk);
      a_rd = 1'b0; a_wr = 1'b0;
      a_mem.mem_ack = 1'b1; a_mem.mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      a_mem.mem_ack = 1'b0; a_mem.mem_rdata = 32'h0;
      #1;
      vectors++;
      if (a_mem.mem_req !== 1'b0 || a_done !== 1'b0 || a_stall !== 1'b0 || a_rdata !== last_rdata || a_err !== 1'b0) begin
         miscompares++;
         $display("FAIL spurious_ack: got req=%b done=%b stall=%b rdata=%h err=%b want 0 0 0 %h 0",
                  a_mem.mem_req, a_done, a_stall, a_rdata, last_rdata, a_err);
      end
      access_a(1'b1, 1'b0, 32'h0000_0140, 32'h0, 1, 32'h0BAD_F00D);
      idle_a(1);
   endtask

   task automatic test_timeout();
      logic [31:0] exp_rd;
      int          reqs;
      @(negedge clk);
      b_rd = 1'b1; b_addr = 32'h0000_0200;
      b_q.push_back(ERR_DATA_DEFAULT);
      #1;
      vectors++;
      if (b_err !== 1'b0 || b_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL to_start: got err=%b stall=%b want 0 1", b_err, b_stall);
      end
      reqs = 0;
      for (int w = 1; w <= 4; w++) begin
         @(negedge clk);
         #1;
         if (b_mem.mem_req === 1'b1 && b_done === 1'b0) reqs++;
      end
      @(negedge clk);
      #1;
      vectors++;
      if (reqs != 4) begin
         miscompares++;
         $display("FAIL to_req_cycles: got %0d want 4", reqs);
      end
      exp_rd = b_q.pop_front();
      vectors++;
      if (b_done !== 1'b1 || b_err !== 1'b1 || b_mem.mem_req !== 1'b0 || b_rdata !== exp_rd) begin
         miscompares++;
         $display("FAIL to_done: got done=%b err=%b req=%b rdata=%h want 1 1 0 %h", b_done, b_err, b_mem.mem_req, b_rdata, exp_rd);
      end
      @(negedge clk);
      b_addr = 32'h0000_0204;
      b_q.push_back(32'h0000_0001);
      @(negedge clk);
      b_mem.mem_ack = 1'b1; b_mem.mem_rdata = 32'h0000_0001;
      #1;
      vectors++;
      if (b_mem.mem_req !== 1'b1 || b_mem.mem_addr !== 32'h0000_0204) begin
         miscompares++;
         $display("FAIL to_next_req: got req=%b addr=%h want 1 00000204", b_mem.mem_req, b_mem.mem_addr);
      end
      @(negedge clk);
      b_mem.mem_ack = 1'b0; b_mem.mem_rdata = 32'h0;
      #1;
      exp_rd = b_q.pop_front();
      vectors++;
      if (b_done !== 1'b1 || b_err !== 1'b1 || b_rdata !== exp_rd) begin
         miscompares++;
         $display("FAIL to_next_done: got done=%b err=%b rdata=%h want 1 1 %h", b_done, b_err, b_rdata, exp_rd);
      end
      @(negedge clk);
      b_rd = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk);
      a_rd = 1'b1; a_wr = 1'b0; a_addr = 32'h0000_0300;
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (a_mem.mem_req !== 1'b1 || a_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_pre: got req=%b stall=%b want 1 1", a_mem.mem_req, a_stall);
      end
      clrn = 1'b0; a_rd = 1'b0;
      #1;
      last_rdata = 32'h0;
      vectors++;
      if ({a_mem.mem_req, a_stall, a_err, a_done} !== 4'b0000 || a_rdata !== 32'h0 || b_err !== 1'b0) begin
         miscompares++;
         $display("FAIL rst_async: got req/stall/err/done=%b rdata=%h b_err=%b want 0000 0 0",
                  {a_mem.mem_req, a_stall, a_err, a_done}, a_rdata, b_err);
      end
      @(negedge clk);
      clrn = 1'b1;
      a_mem.mem_ack = 1'b1; a_mem.mem_rdata = 32'h1234_5678;
      @(negedge clk);
      a_mem.mem_ack = 1'b0; a_mem.mem_rdata = 32'h0;
      #1;
      vectors++;
      if ({a_mem.mem_req, a_stall, a_done} !== 3'b000 || a_rdata !== 32'h0) begin
         miscompares++;
         $display("FAIL rst_late_ack: got req/stall/done=%b rdata=%h want 000 0", {a_mem.mem_req, a_stall, a_done}, a_rdata);
      end
      access_a(1'b1, 1'b0, 32'h0000_0340, 32'h0, 2, 32'h0F0F_0F0F);
      idle_a(1);
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_collision();
      test_back_to_back();
      test_spurious();
      test_timeout();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
